// File: rtl/rv32i_decode_exec.sv
// RV32I decode and integer execute with a single registered commit stage
// carrying writeback (enable/rd/data), next PC and the ebreak flag.
module rv32i_decode_exec #(
  parameter int                     WORD_LENGTH = 32,
  parameter logic [WORD_LENGTH-1:0] RESET_PC    = 32'h80000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WORD_LENGTH-1:0] inst,
  input  logic [WORD_LENGTH-1:0] pc,
  input  logic [WORD_LENGTH-1:0] rs1_data,
  input  logic [WORD_LENGTH-1:0] rs2_data,
  output logic [4:0]             rs1_addr,
  output logic [4:0]             rs2_addr,
  output logic                   wb_en,
  output logic [4:0]             wb_rd,
  output logic [WORD_LENGTH-1:0] wb_data,
  output logic [WORD_LENGTH-1:0] npc,
  output logic                   ebreak
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [WORD_LENGTH-1:0] EBREAK_INST = 32'h00100073;

  logic [6:0]             opcode;
  logic [4:0]             rd;
  logic [2:0]             funct3;
  logic                   funct7_b5;
  logic [WORD_LENGTH-1:0] imm_i, imm_u, imm_j;
  logic [WORD_LENGTH-1:0] src1, src2;
  logic [2:0]             funct3_eff;
  logic                   alt_sub;
  logic [WORD_LENGTH-1:0] alu_res;
  logic [WORD_LENGTH-1:0] pc_plus4;

  logic                   wb_en_d, wb_en_q;
  logic [4:0]             wb_rd_d, wb_rd_q;
  logic [WORD_LENGTH-1:0] wb_data_d, wb_data_q;
  logic [WORD_LENGTH-1:0] npc_d, npc_q;
  logic                   ebreak_d, ebreak_q;

  function automatic logic [WORD_LENGTH-1:0] alu(
    input logic [2:0]             f3,
    input logic                   sub_sel,
    input logic                   alt_sel,
    input logic [WORD_LENGTH-1:0] a,
    input logic [WORD_LENGTH-1:0] b
  );
    logic signed [WORD_LENGTH-1:0] a_s, b_s;
    logic [4:0]                    shamt;
    a_s   = $signed(a);
    b_s   = $signed(b);
    shamt = b[4:0];
    case (f3)
      3'b000:  alu = sub_sel ? (a - b) : (a + b);
      3'b001:  alu = a << shamt;
      3'b010:  alu = {{(WORD_LENGTH-1){1'b0}}, (a_s < b_s)};
      3'b011:  alu = {{(WORD_LENGTH-1){1'b0}}, (a < b)};
      3'b100:  alu = a ^ b;
      3'b101:  alu = alt_sel ? $unsigned(a_s >>> shamt) : (a >> shamt);
      3'b110:  alu = a | b;
      default: alu = a & b;
    endcase
  endfunction

  assign opcode    = inst[6:0];
  assign rd        = inst[11:7];
  assign funct3    = inst[14:12];
  assign funct7_b5 = inst[30];
  assign rs1_addr  = inst[19:15];
  assign rs2_addr  = inst[24:20];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    src1 = '0;
    src2 = '0;
    case (opcode)
      OP_AUIPC: begin src1 = pc;       src2 = imm_u;    end
      OP_JAL:   begin src1 = pc;       src2 = imm_j;    end
      OP_JALR:  begin src1 = rs1_data; src2 = imm_i;    end
      OP_OPIMM: begin src1 = rs1_data; src2 = imm_i;    end
      OP_OP:    begin src1 = rs1_data; src2 = rs2_data; end
      default:  ;
    endcase
  end

  // Only register-register and immediate ALU ops use funct3; everything else adds.
  assign funct3_eff = (opcode == OP_OPIMM || opcode == OP_OP) ? funct3 : 3'b000;
  assign alt_sub    = (opcode == OP_OP) && funct7_b5;
  assign alu_res    = alu(funct3_eff, alt_sub, funct7_b5, src1, src2);

  always_comb begin
    wb_en_d   = 1'b0;
    wb_data_d = '0;
    npc_d     = pc_plus4;
    case (opcode)
      OP_LUI:   begin wb_en_d = 1'b1; wb_data_d = imm_u;    end
      OP_AUIPC: begin wb_en_d = 1'b1; wb_data_d = alu_res;  end
      OP_JAL:   begin wb_en_d = 1'b1; wb_data_d = pc_plus4; npc_d = alu_res; end
      OP_JALR:  begin
        wb_en_d   = 1'b1;
        wb_data_d = pc_plus4;
        npc_d     = {alu_res[WORD_LENGTH-1:1], 1'b0};
      end
      OP_OPIMM: begin wb_en_d = 1'b1; wb_data_d = alu_res;  end
      OP_OP:    begin wb_en_d = 1'b1; wb_data_d = alu_res;  end
      default:  ;
    endcase
    if (rd == 5'd0) begin
      wb_en_d = 1'b0;
    end
  end

  assign wb_rd_d  = rd;
  assign ebreak_d = (inst == EBREAK_INST);

  // Commit stage
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en_q   <= 1'b0;
      wb_rd_q   <= 5'd0;
      wb_data_q <= '0;
      npc_q     <= RESET_PC;
      ebreak_q  <= 1'b0;
    end else begin
      wb_en_q   <= wb_en_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      npc_q     <= npc_d;
      ebreak_q  <= ebreak_d;
    end
  end

  assign wb_en   = wb_en_q;
  assign wb_rd   = wb_rd_q;
  assign wb_data = wb_data_q;
  assign npc     = npc_q;
  assign ebreak  = ebreak_q;

endmodule

// File: tb/tb_rv32i_decode_exec.sv
// Directed bench for rv32i_decode_exec: hand-encoded instructions with
// hand-computed writeback / next-PC values, checked one edge after issue.
module tb_rv32i_decode_exec;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst, pc, rs1_data, rs2_data;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, npc;
  logic        ebreak;

  int checks = 0;
  int errors = 0;

  rv32i_decode_exec #(.WORD_LENGTH(32), .RESET_PC(32'h80000000)) dut (
    .clk      (clk),
    .rst      (rst),
    .inst     (inst),
    .pc       (pc),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .wb_en    (wb_en),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .npc      (npc),
    .ebreak   (ebreak)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [31:0] i, input logic [31:0] p,
                      input logic [31:0] a, input logic [31:0] b);
    inst     = i;
    pc       = p;
    rs1_data = a;
    rs2_data = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    inst = 32'h0; pc = 32'h0; rs1_data = 32'h0; rs2_data = 32'h0;

    // Reset for two cycles with a live-looking instruction present
    step(32'h123450B7, 32'h00001000, 32'h0, 32'h0);
    step(32'h123450B7, 32'h00001000, 32'h0, 32'h0);
    chk("rst_npc",     npc,            32'h80000000);
    chk("rst_wb_en",   {31'b0, wb_en}, 32'd0);
    chk("rst_wb_rd",   {27'b0, wb_rd}, 32'd0);
    chk("rst_wb_data", wb_data,        32'd0);
    chk("rst_ebreak",  {31'b0, ebreak}, 32'd0);

    rst = 1'b0;
    // ADDI x5, x6, -1
    inst = 32'hFFF30293; #1;
    chk("rs1_addr", {27'b0, rs1_addr}, 32'd6);
    chk("rs2_addr", {27'b0, rs2_addr}, 32'd31);
    step(32'hFFF30293, 32'h80000000, 32'd10, 32'd0);
    chk("addi_en",   {31'b0, wb_en}, 32'd1);
    chk("addi_rd",   {27'b0, wb_rd}, 32'd5);
    chk("addi_data", wb_data,        32'd9);
    chk("addi_npc",  npc,            32'h80000004);

    // ADDI with imm bit 10 set must still add
    step(32'h40010093, 32'h80000004, 32'd5, 32'd0);
    chk("addi_b30", wb_data, 32'h00000405);

    step(32'h403100B3, 32'h80000008, 32'd5, 32'd7);
    chk("sub", wb_data, 32'hFFFFFFFE);
    step(32'h003100B3, 32'h80000008, 32'd5, 32'd7);
    chk("add", wb_data, 32'd12);

    step(32'h003120B3, 32'h8000000C, 32'd5, 32'd7);
    chk("slt_5_7", wb_data, 32'd1);
    step(32'h003120B3, 32'h8000000C, 32'd7, 32'd5);
    chk("slt_7_5", wb_data, 32'd0);
    step(32'h003130B3, 32'h8000000C, 32'd7, 32'd5);
    chk("sltu_7_5", wb_data, 32'd0);
    step(32'h003130B3, 32'h8000000C, 32'd5, 32'd7);
    chk("sltu_5_7", wb_data, 32'd1);
    step(32'h003120B3, 32'h8000000C, 32'hFFFFFFFF, 32'd1);
    chk("slt_neg", wb_data, 32'd1);
    step(32'h003130B3, 32'h8000000C, 32'hFFFFFFFF, 32'd1);
    chk("sltu_neg", wb_data, 32'd0);

    step(32'h4040D093, 32'h80000010, 32'h80000000, 32'd0);
    chk("srai", wb_data, 32'hF8000000);
    step(32'h0040D093, 32'h80000010, 32'h80000000, 32'd0);
    chk("srli", wb_data, 32'h08000000);
    step(32'h003110B3, 32'h80000010, 32'd1, 32'h00000021);
    chk("sll_mask", wb_data, 32'd2);
    step(32'h003140B3, 32'h80000010, 32'h0000F0F0, 32'h00000FF0);
    chk("xor", wb_data, 32'h0000FF00);
    step(32'h003160B3, 32'h80000010, 32'h0000F0F0, 32'h00000FF0);
    chk("or", wb_data, 32'h0000FFF0);
    step(32'h003170B3, 32'h80000010, 32'h0000F0F0, 32'h00000FF0);
    chk("and", wb_data, 32'h000000F0);

    step(32'h123450B7, 32'h80000010, 32'd0, 32'd0);
    chk("lui", wb_data, 32'h12345000);
    step(32'h00001097, 32'h80000010, 32'd0, 32'd0);
    chk("auipc", wb_data, 32'h80001010);

    step(32'h008000EF, 32'h80000000, 32'd0, 32'd0);
    chk("jal_npc",  npc,            32'h80000008);
    chk("jal_data", wb_data,        32'h80000004);
    chk("jal_en",   {31'b0, wb_en}, 32'd1);

    step(32'h00328067, 32'h80000020, 32'h80000100, 32'd0);
    chk("jalr_npc", npc,            32'h80000102);
    chk("jalr_en",  {31'b0, wb_en}, 32'd0);

    // rd = x0 suppresses the write
    step(32'h00100013, 32'h80000030, 32'd0, 32'd0);
    chk("rd0_en", {31'b0, wb_en}, 32'd0);

    step(32'h0020A023, 32'h80000040, 32'h1000, 32'h55);
    chk("sw_en",  {31'b0, wb_en}, 32'd0);
    chk("sw_npc", npc,            32'h80000044);
    step(32'h00000463, 32'h80000050, 32'd0, 32'd0);
    chk("beq_en",  {31'b0, wb_en}, 32'd0);
    chk("beq_npc", npc,            32'h80000054);
    step(32'h000000FF, 32'h80000060, 32'd0, 32'd0);
    chk("unk_en",  {31'b0, wb_en}, 32'd0);
    chk("unk_npc", npc,            32'h80000064);

    step(32'h00100073, 32'h80000070, 32'd0, 32'd0);
    chk("ebrk_flag", {31'b0, ebreak}, 32'd1);
    chk("ebrk_en",   {31'b0, wb_en},  32'd0);
    chk("ebrk_npc",  npc,             32'h80000074);
    step(32'h00000013, 32'h80000074, 32'd0, 32'd0);
    chk("ebrk_drop", {31'b0, ebreak}, 32'd0);

    // Mid-stream reset discards the presented instruction
    rst = 1'b1;
    step(32'h123450B7, 32'h80000080, 32'd0, 32'd0);
    chk("mrst_en",  {31'b0, wb_en}, 32'd0);
    chk("mrst_npc", npc,            32'h80000000);
    rst = 1'b0;
    step(32'h123450B7, 32'h80000080, 32'd0, 32'd0);
    chk("post_rst_data", wb_data, 32'h12345000);
    chk("post_rst_npc",  npc,     32'h80000084);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32i_decode_exec.md
# rv32i_decode_exec

Combinational RV32I decode and integer-execute datapath with a one-stage registered writeback/next-PC output. It sits between instruction fetch and the register file/PC register of the single-cycle core. It performs four jobs:
- decodes the instruction fields and immediates;
- selects ALU operands by opcode;
- computes the ALU result, register write data and next PC;
- registers these values for commit on the following clock edge.

## Interface
- `WORD_LENGTH`, default 32: datapath width. Only 32 is supported.
- `RESET_PC`, default 32'h80000000: value of `npc` while in reset.
- One clock; reset is synchronous and active-high (`clk`, `rst`).
- `clk`, input, 1: clock. All registers update on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `inst`, input, 32: current instruction.
- `pc`, input, 32: address of `inst`.
- `rs1_data`, input, 32: register file value for `rs1_addr`, returned combinationally.
- `rs2_data`, input, 32: register file value for `rs2_addr`, returned combinationally.
- `rs1_addr`, output, 5: `inst[19:15]`. Combinational.
- `rs2_addr`, output, 5: `inst[24:20]`. Combinational.
- `wb_en`, output, 1: registered. Register write enable for the committed instruction.
- `wb_rd`, output, 5: registered. Destination register.
- `wb_data`, output, 32: registered. Destination write data.
- `npc`, output, 32: registered. Next PC to load into the PC register.
- `ebreak`, output, 1: registered. Asserted when the committed instruction is exactly 32'h00100073.

## Operation
- Instruction fields:
  - opcode = `inst[6:0]`; rd = `inst[11:7]`; funct3 = `inst[14:12]`; funct7 = `inst[31:25]`.
- Immediates (sext = sign-extend from the MSB shown):
  - I = sext(`inst[31:20]`).
  - S = sext({`inst[31:25]`, `inst[11:7]`}).
  - B = sext({`inst[31]`, `inst[7]`, `inst[30:25]`, `inst[11:8]`, 0}).
  - U = {`inst[31:12]`, 12'b0}.
  - J = sext({`inst[31]`, `inst[19:12]`, `inst[20]`, `inst[30:21]`, 0}).
- Operand selection is a keyed mux (key = opcode, default 0). `src1`/`src2` per opcode:
  - AUIPC 0010111: `pc` / U.
  - JAL 1101111: `pc` / J.
  - JALR 1100111: `rs1_data` / I.
  - OP-IMM 0010011: `rs1_data` / I.
  - OP 0110011: `rs1_data` / `rs2_data`.
- ALU operation funct3 (effective):
  - Effective funct3 equals `inst` funct3 only for OP-IMM and OP. For all other opcodes it is forced to 000, so the ALU adds.
- ALU operations by effective funct3:
  - 000: ADD. SUB only when opcode = OP and funct7[5] = 1.
  - 001: SLL.
  - 010: SLT (signed).
  - 011: SLTU.
  - 100: XOR.
  - 101: SRL, or SRA when funct7[5] = 1. Applies to both OP and OP-IMM.
  - 110: OR.
  - 111: AND.
- ALU arithmetic rules:
  - Shift amount = `src2[4:0]`.
  - SLT and SLTU produce 0 or 1, zero-extended to 32 bits.
  - Add and subtract wrap modulo 2^32.
- Write data (keyed by opcode):
  - LUI 0110111: U.
  - AUIPC: ALU result.
  - JAL and JALR: `pc` + 4.
  - OP-IMM and OP: ALU result.
  - Anything else: 0.
- Write enable: set for LUI, AUIPC, JAL, JALR, OP-IMM and OP, and only when rd ≠ 0.
  - For rd = 0 the write is suppressed: `wb_en` = 0 and `wb_data` is don't-care.
- Next PC:
  - JAL: ALU result (`pc` + J).
  - JALR: ALU result & ~1.
  - All other opcodes, including branches, loads, stores, SYSTEM and unknown encodings: `pc` + 4.
  - Loads, stores, branches, SYSTEM and unknown opcodes write no register (`wb_en` = 0).

## Timing
- Decode, operand muxing, ALU, write data and next PC are purely combinational within the cycle.
- `rs1_addr`/`rs2_addr` have zero latency.
- Registered outputs capture the current instruction's results on each rising `clk`, so the latency from `inst`/`pc` to `wb_*`/`npc`/`ebreak` is 1 cycle.
- There is no stall or handshake: a new instruction is accepted every cycle.
- While `rst` = 1 at a rising edge: `wb_en` = 0, `wb_rd` = 0, `wb_data` = 0, `npc` = `RESET_PC`, `ebreak` = 0.
  - Reset asserted mid-stream discards the instruction presented in that cycle.
  - On the first edge after `rst` deasserts, the outputs reflect the instruction presented in that cycle.
- `inst` = X or an unknown opcode must not produce `wb_en` = 1.

## Test plan
- Reset: hold `rst` for 2 cycles with any `inst`. Expect `npc` = 32'h80000000, `wb_en` = 0, `ebreak` = 0.
- ADDI x5, x6, -1 (32'hFFF30293) with `rs1_data` = 10 and `pc` = 32'h80000000. After one edge: `wb_en` = 1, `wb_rd` = 5, `wb_data` = 9, `npc` = 32'h80000004.
- OP SUB x1, x2, x3 with `rs1_data` = 5, `rs2_data` = 7. Expect `wb_data` = 32'hFFFFFFFE.
- Same register values with funct3 = 010 (SLT) and 011 (SLTU); swap operands to check both the signed and unsigned comparisons. Expect 1, 0, 0, 1 respectively.
- SRAI x1, x1, 4 (32'h4040D093) with `rs1_data` = 32'h80000000. Expect `wb_data` = 32'hF8000000.
- LUI x1, 0x12345 → `wb_data` = 32'h12345000.
- AUIPC x1, 1 at `pc` = 32'h80000010 → `wb_data` = 32'h80001010.
- JAL x1, +8 at `pc` = 32'h80000000 → `npc` = 32'h80000008, `wb_data` = 32'h80000004.
- JALR x0, 3(x5) with `rs1_data` = 32'h80000100 → `npc` = 32'h80000102, `wb_en` = 0.
- Store, branch or ebreak (32'h00100073) → `wb_en` = 0 and `npc` = `pc` + 4. For ebreak only, `ebreak` = 1 for exactly one cycle.
